mips_cpu_core: RTL and testbench
================================

// Module: mips_cpu_core
// PURPOSE
// Single-cycle 32-bit MIPS-subset core, executing one instruction per enabled clock.
// - Drives pc to an external instruction memory. That memory is read combinationally: inst is valid in the same cycle as pc.
// - Holds a private register file and data memory.
// - Publishes a registered retire/trace port for the bench checker, including a one-cycle op_done pulse per committed instruction.
// PARAMETERS
// RESET_PC    32'h0000_0000   pc value loaded on reset
// DMEM_WORDS  256             internal data memory depth, 32-bit words, power of 2
// HALT_WORD   32'hFFFF_FFFF   instruction encoding that halts the core
// PORTS
// clk        in   1   single clock; all state updates on posedge
// reset      in   1   synchronous, active-high
// pcEn       in   1   execute enable; low = freeze all architectural state
// pc         out  32  address of the current instruction (byte address, word aligned)
// inst       in   32  instruction at pc, valid in the same cycle
// op_done    out  1   registered pulse: one instruction committed in the previous cycle
// wb_en      out  1   registered: that instruction wrote a GPR (never for $0)
// wb_reg     out  5   registered: destination register index
// wb_data    out  32  registered: value written
// st_en      out  1   registered: that instruction was a store
// st_addr    out  32  registered: store byte address
// st_data    out  32  registered: store data
// halted     out  1   sticky: HALT_WORD was executed
// illegal    out  1   registered pulse: unsupported encoding was retired as NOP
// BEHAVIOUR
// Reset:
// - pc = RESET_PC.
// - All 32 GPRs = 0; data memory is not cleared.
// - All trace outputs, halted and illegal = 0.
// - Reset has priority over pcEn and over a halt in progress.
// Commit condition: a commit happens on a posedge with pcEn=1, reset=0 and halted=0.
// - Execute inst and update the GPR/DMEM.
// - pc <= next_pc.
// - Trace outputs are registered: they reflect that commit one cycle later (latency 1).
// No-commit cycles (pcEn=0 or halted=1):
// - pc, GPRs and DMEM hold.
// - op_done, wb_en, st_en and illegal are 0 the next cycle.
// - wb_reg, wb_data, st_addr and st_data hold their last values.
// next_pc:
// - Default: pc+4.
// - Taken beq/bne: pc+4+(sext(imm16)<<2).
// - j: {pc4[31:28], addr26, 2'b00}.
// - No delay slot; 32-bit wrap.
// Supported instructions:
// - R-type, opcode 0, by funct: add 20h, sub 22h, and 24h, or 25h, slt 2Ah (signed), sll 00h, srl 02h (shift by shamt).
// - I-type: addi 08h, slti 0Ah (signed), andi 0Ch (zero-extend), ori 0Dh (zero-extend), lui 0Fh (imm<<16), lw 23h, sw 2Bh, beq 04h, bne 05h.
// - J-type: j 02h.
// Arithmetic: two's complement wraps; no overflow trap.
// Register file:
// - $0 reads 0; writes to $0 are dropped and give wb_en=0.
// - Reads are combinational; the write occurs at the commit edge.
// Data memory:
// - Effective address = rs + sext(imm16); the word index uses addr[log2(DMEM_WORDS)+1:2].
// - Upper bits and addr[1:0] are ignored, so addresses wrap modulo DMEM size.
// - lw reads combinationally (same cycle); sw writes at the commit edge.
// Special encodings:
// - inst == 0 is a NOP: op_done=1, wb_en=0.
// - Unsupported opcode/funct is retired as a NOP with illegal=1 one cycle later.
// - inst == HALT_WORD: halted <= 1, pc holds, op_done=1 with no writeback; further instructions are ignored until reset.
// Simultaneous events: reset together with pcEn=1 -> reset wins; no commit, no trace.
// TESTING
// - Reset for 2 cycles, pcEn=1 -> pc sequence 0,4,8..., no op_done in the first post-reset cycle, GPR reads all 0.
// - addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 -> wb trace (1,5), (2,FFFF_FFFD), (3,2), each one cycle after its commit.
// - sw $3,8($0); lw $4,8($0) -> st_en, st_addr=8, st_data=2; then wb (4,2). Also sw at addr 8+4*DMEM_WORDS aliases to addr 8.
// - beq $1,$1,+2 at pc=0x10 -> next pc 0x1C; bne not taken -> pc+4; j 0x40 -> pc=0x100.
// - Toggle pcEn=0 for 3 cycles mid-program -> pc, GPRs and DMEM frozen, op_done=0, then execution resumes.
// - Feed 32'hFFFF_FFFF -> one op_done, halted=1, pc frozen. Assert reset -> pc=RESET_PC, halted=0. An illegal opcode 3Fh pulses illegal.

Source files
------------

// File: rtl/mips_cpu_core_if.sv
// Instruction fetch and retire/trace bus of the single-cycle MIPS core.
// master = core side, slave = memory/checker side.
interface mips_cpu_core_if;
  logic        pcEn;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        op_done;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        st_en;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        halted;
  logic        illegal;

  modport master (
    input  pcEn, inst,
    output pc, op_done, wb_en, wb_reg, wb_data,
    output st_en, st_addr, st_data, halted, illegal
  );

  modport slave (
    output pcEn, inst,
    input  pc, op_done, wb_en, wb_reg, wb_data,
    input  st_en, st_addr, st_data, halted, illegal
  );
endinterface

// File: rtl/mips_cpu_core.sv
// Single-cycle 32-bit MIPS-subset core with private GPRs and data memory.
// Trace outputs report each commit one cycle after it happens.
module mips_cpu_core #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic clk,
  input  logic reset,
  mips_cpu_core_if.master bus
);
  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0] rf_q [32];
  logic [31:0] dmem_q [DMEM_WORDS];

  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic        op_done_q, op_done_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        st_en_q, st_en_d;
  logic [31:0] st_addr_q, st_addr_d;
  logic [31:0] st_data_q, st_data_d;
  logic        illegal_q, illegal_d;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sh;
  logic [15:0] imm;
  logic [31:0] rs_v, rt_v, imm_s, imm_z;
  logic [31:0] ea, pc4, br;
  logic [AW-1:0] idx;
  logic        wr, st, ill, halt, commit;
  logic [4:0]  dst;
  logic [31:0] res, npc;

  always_comb begin
    op    = bus.inst[31:26];
    rs    = bus.inst[25:21];
    rt    = bus.inst[20:16];
    rd    = bus.inst[15:11];
    sh    = bus.inst[10:6];
    fn    = bus.inst[5:0];
    imm   = bus.inst[15:0];
    rs_v  = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    rt_v  = (rt == 5'd0) ? 32'd0 : rf_q[rt];
    imm_s = {{16{imm[15]}}, imm};
    imm_z = {16'd0, imm};
    ea    = rs_v + imm_s;
    idx   = ea[AW+1:2];
    pc4   = pc_q + 32'd4;
    br    = pc4 + {imm_s[29:0], 2'b00};

    wr   = 1'b0;
    st   = 1'b0;
    ill  = 1'b0;
    halt = 1'b0;
    dst  = rt;
    res  = 32'd0;
    npc  = pc4;

    if (bus.inst == HALT_WORD) begin
      halt = 1'b1;
      npc  = pc_q;
    end else if (bus.inst != 32'd0) begin
      unique case (op)
        6'h00: begin
          wr  = 1'b1;
          dst = rd;
          unique case (fn)
            6'h20: res = rs_v + rt_v;
            6'h22: res = rs_v - rt_v;
            6'h24: res = rs_v & rt_v;
            6'h25: res = rs_v | rt_v;
            6'h2A: res = {31'd0, $signed(rs_v) < $signed(rt_v)};
            6'h00: res = rt_v << sh;
            6'h02: res = rt_v >> sh;
            default: begin
              wr  = 1'b0;
              ill = 1'b1;
            end
          endcase
        end
        6'h08: begin wr = 1'b1; res = rs_v + imm_s; end
        6'h0A: begin
          wr  = 1'b1;
          res = {31'd0, $signed(rs_v) < $signed(imm_s)};
        end
        6'h0C: begin wr = 1'b1; res = rs_v & imm_z; end
        6'h0D: begin wr = 1'b1; res = rs_v | imm_z; end
        6'h0F: begin wr = 1'b1; res = {imm, 16'd0}; end
        6'h23: begin wr = 1'b1; res = dmem_q[idx]; end
        6'h2B: st = 1'b1;
        6'h04: if (rs_v == rt_v) npc = br;
        6'h05: if (rs_v != rt_v) npc = br;
        6'h02: npc = {pc4[31:28], bus.inst[25:0], 2'b00};
        default: ill = 1'b1;
      endcase
    end

    // $0 writes are dropped entirely, including from the trace
    if (dst == 5'd0) wr = 1'b0;

    commit    = bus.pcEn && !halted_q;
    pc_d      = pc_q;
    halted_d  = halted_q;
    op_done_d = 1'b0;
    wb_en_d   = 1'b0;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;
    st_en_d   = 1'b0;
    st_addr_d = st_addr_q;
    st_data_d = st_data_q;
    illegal_d = 1'b0;

    if (commit) begin
      pc_d      = npc;
      halted_d  = halt;
      op_done_d = 1'b1;
      wb_en_d   = wr;
      st_en_d   = st;
      illegal_d = ill;
      if (wr) begin
        wb_reg_d  = dst;
        wb_data_d = res;
      end
      if (st) begin
        st_addr_d = ea;
        st_data_d = rt_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      halted_q  <= 1'b0;
      op_done_q <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= 5'd0;
      wb_data_q <= 32'd0;
      st_en_q   <= 1'b0;
      st_addr_q <= 32'd0;
      st_data_q <= 32'd0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      pc_q      <= pc_d;
      halted_q  <= halted_d;
      op_done_q <= op_done_d;
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
      st_en_q   <= st_en_d;
      st_addr_q <= st_addr_d;
      st_data_q <= st_data_d;
      illegal_q <= illegal_d;
      if (commit && wr) rf_q[dst] <= res;
    end
  end

  // data memory is deliberately left uncleared by reset
  always_ff @(posedge clk) begin
    if (!reset && commit && st) dmem_q[idx] <= rt_v;
  end

  assign bus.pc      = pc_q;
  assign bus.op_done = op_done_q;
  assign bus.wb_en   = wb_en_q;
  assign bus.wb_reg  = wb_reg_q;
  assign bus.wb_data = wb_data_q;
  assign bus.st_en   = st_en_q;
  assign bus.st_addr = st_addr_q;
  assign bus.st_data = st_data_q;
  assign bus.halted  = halted_q;
  assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_mips_cpu_core.sv
// Directed bench for mips_cpu_core: runs a fixed program from a
// combinational instruction ROM and checks the retire trace.
module tb_mips_cpu_core;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] imem [256];
  int passed = 0;
  int total  = 0;

  mips_cpu_core_if bus ();

  mips_cpu_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.inst = imem[bus.pc[9:2]];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input string tag,
                    input logic [31:0] pc,
                    input logic [4:0] r,
                    input logic [31:0] d);
    step();
    chk({tag, ".pc"}, bus.pc, pc);
    chk({tag, ".done"}, 32'(bus.op_done), 32'd1);
    chk({tag, ".wben"}, 32'(bus.wb_en), 32'd1);
    chk({tag, ".reg"}, 32'(bus.wb_reg), 32'(r));
    chk({tag, ".data"}, bus.wb_data, d);
  endtask

  task automatic nowb(input string tag,
                      input logic [31:0] pc);
    step();
    chk({tag, ".pc"}, bus.pc, pc);
    chk({tag, ".done"}, 32'(bus.op_done), 32'd1);
    chk({tag, ".wben"}, 32'(bus.wb_en), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
    imem[0]  = 32'h2001_0005; // addi $1,$0,5
    imem[1]  = 32'h2002_FFFD; // addi $2,$0,-3
    imem[2]  = 32'h0022_1820; // add $3,$1,$2
    imem[3]  = 32'hAC03_0008; // sw $3,8($0)
    imem[4]  = 32'h1021_0002; // beq $1,$1,+2
    imem[5]  = 32'h200D_0001;
    imem[6]  = 32'h200D_0001;
    imem[7]  = 32'h8C04_0008; // lw $4,8($0)
    imem[8]  = 32'h1421_0005; // bne $1,$1 (not taken)
    imem[9]  = 32'hAC01_0408; // sw $1,1032($0)
    imem[10] = 32'h8C05_0008; // lw $5,8($0)
    imem[11] = 32'h0800_0040; // j 0x100
    imem[64] = 32'h0061_3022; // sub $6,$3,$1
    imem[65] = 32'h0041_382A; // slt $7,$2,$1
    imem[66] = 32'h3C08_1234; // lui $8,0x1234
    imem[67] = 32'h3508_FFFF; // ori $8,$8,0xFFFF
    imem[68] = 32'h0001_4900; // sll $9,$1,4
    imem[69] = 32'h0002_5702; // srl $10,$2,28
    imem[70] = 32'h284B_FFFE; // slti $11,$2,-2
    imem[71] = 32'h304C_FF0F; // andi $12,$2,0xFF0F
    imem[72] = 32'h0000_0000; // nop
    imem[73] = 32'hFC00_0000; // illegal opcode 3Fh
    imem[74] = 32'h2000_0007; // addi $0,$0,7
    imem[75] = 32'hFFFF_FFFF; // halt

    reset = 1'b1;
    bus.pcEn = 1'b1;
    step();
    step();
    chk("rst.pc", bus.pc, 32'h0);
    chk("rst.done", 32'(bus.op_done), 32'd0);
    chk("rst.halted", 32'(bus.halted), 32'd0);
    chk("rst.illegal", 32'(bus.illegal), 32'd0);
    chk("rst.wben", 32'(bus.wb_en), 32'd0);
    chk("rst.sten", 32'(bus.st_en), 32'd0);
    reset = 1'b0;
    #1;
    chk("post.done", 32'(bus.op_done), 32'd0);

    wb("addi1", 32'h04, 5'd1, 32'h5);
    wb("addi2", 32'h08, 5'd2, 32'hFFFF_FFFD);
    wb("add3", 32'h0C, 5'd3, 32'h2);

    bus.pcEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz.pc", bus.pc, 32'h0C);
      chk("frz.done", 32'(bus.op_done), 32'd0);
      chk("frz.wben", 32'(bus.wb_en), 32'd0);
      chk("frz.reg", 32'(bus.wb_reg), 32'd3);
      chk("frz.data", bus.wb_data, 32'h2);
    end
    bus.pcEn = 1'b1;

    nowb("sw", 32'h10);
    chk("sw.sten", 32'(bus.st_en), 32'd1);
    chk("sw.addr", bus.st_addr, 32'h8);
    chk("sw.data", bus.st_data, 32'h2);
    nowb("beq", 32'h1C);
    chk("beq.sten", 32'(bus.st_en), 32'd0);
    wb("lw4", 32'h20, 5'd4, 32'h2);
    nowb("bne", 32'h24);
    nowb("swal", 32'h28);
    chk("swal.sten", 32'(bus.st_en), 32'd1);
    chk("swal.addr", bus.st_addr, 32'h408);
    chk("swal.data", bus.st_data, 32'h5);
    wb("lw5", 32'h2C, 5'd5, 32'h5);
    nowb("j", 32'h100);

    wb("sub", 32'h104, 5'd6, 32'hFFFF_FFFD);
    wb("slt", 32'h108, 5'd7, 32'h1);
    wb("lui", 32'h10C, 5'd8, 32'h1234_0000);
    wb("ori", 32'h110, 5'd8, 32'h1234_FFFF);
    wb("sll", 32'h114, 5'd9, 32'h50);
    wb("srl", 32'h118, 5'd10, 32'hF);
    wb("slti", 32'h11C, 5'd11, 32'h1);
    wb("andi", 32'h120, 5'd12, 32'hFF0D);
    nowb("nop", 32'h124);
    chk("nop.ill", 32'(bus.illegal), 32'd0);
    nowb("ill", 32'h128);
    chk("ill.ill", 32'(bus.illegal), 32'd1);
    nowb("r0", 32'h12C);
    chk("r0.ill", 32'(bus.illegal), 32'd0);
    nowb("halt", 32'h12C);
    chk("halt.h", 32'(bus.halted), 32'd1);
    step();
    chk("hold.pc", bus.pc, 32'h12C);
    chk("hold.done", 32'(bus.op_done), 32'd0);
    chk("hold.h", 32'(bus.halted), 32'd1);

    reset = 1'b1;
    step();
    chk("rst2.pc", bus.pc, 32'h0);
    chk("rst2.h", 32'(bus.halted), 32'd0);
    chk("rst2.done", 32'(bus.op_done), 32'd0);
    reset = 1'b0;
    wb("re.addi1", 32'h04, 5'd1, 32'h5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
